// File: rtl/usr_pkg.sv
// Shared types for the USR operation sequencer: op codes, FSM states, width.
package usr_pkg;

    localparam int USR_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DRIVE  = 2'b01,
        ST_SETTLE = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    // LOAD always takes one cycle; a zero count still means one cycle.
    function automatic logic [3:0] eff_count(op_e op, logic [3:0] cnt);
        if (op == OP_LOAD || cnt == 4'd0) begin
            return 4'd1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/usr_op_sequencer.sv
// Sequences one command onto a 4-bit universal shift register and
// returns the register contents once the operation has settled.
module usr_op_sequencer
    import usr_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [USR_WIDTH-1:0] cmd_data,
    input  logic [3:0]           cmd_count,
    input  logic                 cmd_sin,
    output logic [1:0]           select,
    output logic [USR_WIDTH-1:0] p_din,
    output logic                 s_right_din,
    output logic                 s_left_din,
    input  logic [USR_WIDTH-1:0] p_dout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [USR_WIDTH-1:0] rsp_data,
    output logic                 busy
);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [USR_WIDTH-1:0] data_q, data_d;
    logic                 sin_q, sin_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [USR_WIDTH-1:0] rsp_data_q, rsp_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (cmd_valid) state_d = ST_DRIVE;
            ST_DRIVE:  if (cnt_q == 4'd1) state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_HOLD;
            data_q     <= '0;
            sin_q      <= 1'b0;
            cnt_q      <= 4'd0;
            rsp_data_q <= '0;
        end else begin
            op_q       <= op_d;
            data_q     <= data_d;
            sin_q      <= sin_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Command capture, DRIVE down-count and the SETTLE snapshot of p_dout.
    always_comb begin
        op_d       = op_q;
        data_d     = data_q;
        sin_d      = sin_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        if (state_q == ST_IDLE && cmd_valid) begin
            op_d   = op_e'(cmd_op);
            data_d = cmd_data;
            sin_d  = cmd_sin;
            cnt_d  = eff_count(op_e'(cmd_op), cmd_count);
        end
        if (state_q == ST_DRIVE) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (state_q == ST_SETTLE) begin
            rsp_data_d = p_dout;
        end
    end

    always_comb begin
        select      = OP_HOLD;
        p_din       = '0;
        s_right_din = 1'b0;
        s_left_din  = 1'b0;
        cmd_ready   = (state_q == ST_IDLE);
        rsp_valid   = (state_q == ST_RESP);
        busy        = (state_q != ST_IDLE);
        rsp_data    = rsp_data_q;
        if (state_q == ST_DRIVE) begin
            select      = op_q;
            p_din       = data_q;
            s_right_din = sin_q;
            s_left_din  = sin_q;
        end
    end

endmodule

// File: tb/tb_usr_op_sequencer.sv
// Directed bench for usr_op_sequencer with an attached USR and a
// cycle-level reference of the command/response timeline.
module tb_usr_op_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic [3:0] cmd_count = 4'h0;
    logic       cmd_sin = 1'b0;
    logic [1:0] select;
    logic [3:0] p_din;
    logic       s_right_din;
    logic       s_left_din;
    logic [3:0] p_dout;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       busy;

    int n_pass = 0;
    int n_tot = 0;

    usr_op_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_count(cmd_count), .cmd_sin(cmd_sin),
        .select(select), .p_din(p_din),
        .s_right_din(s_right_din), .s_left_din(s_left_din),
        .p_dout(p_dout), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // The shift register the sequencer controls.
    logic [3:0] usr_q = 4'h0;
    assign p_dout = usr_q;
    always @(posedge clk) begin
        case (select)
            2'b01:   usr_q <= {s_right_din, usr_q[3:1]};
            2'b10:   usr_q <= {usr_q[2:0], s_left_din};
            2'b11:   usr_q <= p_din;
            default: usr_q <= usr_q;
        endcase
    end

    task automatic chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int eff(logic [1:0] op, logic [3:0] c);
        if (op == 2'b11 || c == 4'd0) return 1;
        return int'(c);
    endfunction

    function automatic logic [3:0] apply(logic [3:0] v, logic [1:0] op,
                                         logic [3:0] d, int n, logic s);
        logic [3:0] r;
        r = v;
        case (op)
            2'b11: r = d;
            2'b01: for (int i = 0; i < n; i++) r = {s, r[3:1]};
            2'b10: for (int i = 0; i < n; i++) r = {r[2:0], s};
            default: r = v;
        endcase
        return r;
    endfunction

    // Reference: age counts cycles since the accept cycle.
    bit         m_live = 0;
    bit         m_busy = 0;
    int         m_age = 0;
    int         m_n = 1;
    logic [1:0] m_op = 2'b00;
    logic [3:0] m_data = 4'h0;
    logic       m_sin = 1'b0;
    logic [3:0] m_reg = 4'h0;
    logic [3:0] m_res = 4'h0;
    logic [3:0] m_rdata = 4'h0;

    always @(posedge clk) begin
        if (reset) begin
            m_live  <= 1;
            m_busy  <= 0;
            m_age   <= 0;
            m_rdata <= 4'h0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy <= 1;
                m_age  <= 1;
                m_n    <= eff(cmd_op, cmd_count);
                m_op   <= cmd_op;
                m_data <= cmd_data;
                m_sin  <= cmd_sin;
                m_res  <= apply(m_reg, cmd_op, cmd_data, eff(cmd_op, cmd_count), cmd_sin);
                m_reg  <= apply(m_reg, cmd_op, cmd_data, eff(cmd_op, cmd_count), cmd_sin);
            end
        end else if (m_age < m_n + 2) begin
            m_age <= m_age + 1;
            if (m_age == m_n + 1) m_rdata <= m_res;
        end else if (rsp_ready) begin
            m_busy <= 0;
        end
    end

    always @(negedge clk) begin
        bit drv, rsp;
        if (m_live) begin
            drv = m_busy && m_age <= m_n;
            rsp = m_busy && m_age == m_n + 2;
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("select", select, drv ? m_op : 2'b00);
            chk("p_din", p_din, drv ? m_data : 4'h0);
            chk("s_right_din", s_right_din, drv ? m_sin : 1'b0);
            chk("s_left_din", s_left_din, drv ? m_sin : 1'b0);
            chk("rsp_valid", rsp_valid, rsp);
            chk("rsp_data", rsp_data, m_rdata);
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] cnt;
        logic       sin;
        int         hold;
        bit         early;
        logic [3:0] exp;
    } vec_t;

    task automatic send(vec_t v, string nm);
        int lat;
        int w;
        w = 0;
        while (!cmd_ready && w < 10) begin
            @(posedge clk); #1; w++;
        end
        chk({nm, ".ready_timeout"}, cmd_ready, 1);
        cmd_valid = 1; cmd_op = v.op; cmd_data = v.data;
        cmd_count = v.cnt; cmd_sin = v.sin;
        @(posedge clk); #1;
        cmd_valid = 0; cmd_data = 4'h0;
        if (v.op != 2'b11) chk({nm, ".first_select"}, select, v.op);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            rsp_ready = v.early && (lat < eff(v.op, v.cnt));
            @(posedge clk); #1; lat++;
        end
        rsp_ready = 0;
        chk({nm, ".latency"}, lat, eff(v.op, v.cnt) + 2);
        chk({nm, ".rsp_data"}, rsp_data, v.exp);
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = h[0]; cmd_op = 2'b11; cmd_data = 4'h3;
            @(posedge clk); #1;
        end
        cmd_valid = 1; cmd_op = 2'b11; cmd_data = 4'h6;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0; cmd_valid = 0; cmd_data = 4'h0;
        chk({nm, ".idle_after"}, cmd_ready, 1);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{2'b11, 4'hA, 4'd0,  1'b0, 0, 0, 4'hA};
        vecs[1] = '{2'b11, 4'h1, 4'd0,  1'b0, 1, 0, 4'h1};
        vecs[2] = '{2'b10, 4'h0, 4'd3,  1'b0, 0, 0, 4'h8};
        vecs[3] = '{2'b11, 4'hF, 4'd0,  1'b0, 0, 0, 4'hF};
        vecs[4] = '{2'b01, 4'h0, 4'd0,  1'b0, 5, 0, 4'h7};
        vecs[5] = '{2'b01, 4'h9, 4'd2,  1'b1, 2, 1, 4'hD};
        vecs[6] = '{2'b10, 4'h0, 4'd15, 1'b1, 0, 1, 4'hF};
        vecs[7] = '{2'b00, 4'h2, 4'd2,  1'b1, 0, 0, 4'hF};
        vecs[8] = '{2'b11, 4'h5, 4'd9,  1'b0, 0, 0, 4'h5};
        vecs[9] = '{2'b10, 4'h0, 4'd1,  1'b1, 3, 0, 4'hB};

        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("reset.cmd_ready", cmd_ready, 1);
        chk("reset.rsp_data", rsp_data, 0);
        chk("reset.select", select, 0);
        chk("reset.busy", busy, 0);

        for (int i = 0; i < 10; i++) send(vecs[i], $sformatf("v%0d", i));

        // Reset in the second DRIVE cycle of SHR count 5.
        cmd_valid = 1; cmd_op = 2'b01; cmd_count = 4'd5; cmd_sin = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 0;
        @(posedge clk); #1;
        chk("mid.select", select, 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("rst.select", select, 0);
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.cmd_ready", cmd_ready, 1);
        chk("rst.rsp_data", rsp_data, 0);

        send('{2'b11, 4'h3, 4'd0, 1'b0, 0, 0, 4'h3}, "post_load");
        send('{2'b01, 4'h0, 4'd4, 1'b1, 1, 0, 4'hF}, "post_shr");

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/usr_op_sequencer.md
USR_OP_SEQUENCER -- requirements
Module: usr_op_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock shared with the 4-bit universal shift register (USR).
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  2  operation: 00 HOLD, 01 SHR, 10 SHL, 11 LOAD.
REQ-007 cmd_data  input  4  parallel load value; used by LOAD only.
REQ-008 cmd_count  input  4  number of USR cycles to apply op; 0 treated as 1; ignored for LOAD.
REQ-009 cmd_sin  input  1  serial fill bit used for SHR/SHL.
REQ-010 select  output  2  USR operation select, same encoding as cmd_op.
REQ-011 p_din  output  4  USR parallel data in.
REQ-012 s_right_din  output  1  USR serial input for SHR.
REQ-013 s_left_din  output  1  USR serial input for SHL.
REQ-014 p_dout  input  4  USR parallel data out.
REQ-015 rsp_valid  output  1  result available.
REQ-016 rsp_ready  input  1  consumer accepts result.
REQ-017 rsp_data  output  4  p_dout captured after the operation completes.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, DRIVE, SETTLE, RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle where cmd_valid && cmd_ready.
REQ-021 On accept: latch op, data, sin and effective count (LOAD -> 1; count 0 -> 1; else cmd_count); next state DRIVE.
REQ-022 In DRIVE, select = latched op; p_din = latched data; s_right_din = s_left_din = latched sin; a 4-bit down-counter starts at the effective count and decrements each DRIVE cycle.
REQ-023 DRIVE SHALL last exactly the effective count cycles (1..15), then go to SETTLE.
REQ-024 In SETTLE (1 cycle) select = 00; at the end of the cycle p_dout is registered into rsp_data; next state RESP.
REQ-025 In RESP rsp_valid = 1 and rsp_data stays stable until rsp_ready is sampled 1, then IDLE.
REQ-026 If rsp_valid and rsp_ready are both 1, the state SHALL be IDLE on the next cycle and cmd_ready SHALL be 1; no back-to-back accept from RESP.
REQ-027 Outside DRIVE: select = 00, p_din = 0, s_right_din = s_left_din = 0.
REQ-028 Latency from accept to rsp_valid SHALL be effective count + 2 cycles.
REQ-029 Command inputs SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RESP.

Reset
REQ-030 Reset SHALL take priority over all other events, including mid-DRIVE and mid-RESP, and return the FSM to IDLE in the same edge.
REQ-031 Reset values: select 00, p_din 0, s_right_din 0, s_left_din 0, rsp_valid 0, rsp_data 0, busy 0, cmd_ready 1 (first cycle after reset release), counter 0.

Structure
REQ-032 A shared package usr_pkg SHALL hold the op enum (HOLD/SHR/SHL/LOAD, 2 bits), the FSM state enum and constant USR_WIDTH = 4.
REQ-033 The design SHALL be a single module; no sub-module.

Verification
REQ-034 LOAD cmd_data=4'hA -> select=11 for 1 cycle, rsp_valid 2 cycles later, rsp_data=4'hA.
REQ-035 After LOAD 4'h1, SHL count=3 sin=0 -> select=10 for exactly 3 cycles, rsp_data=4'h8.
REQ-036 After LOAD 4'hF, SHR count=0 sin=0 -> exactly 1 SHR cycle, rsp_data=4'h7.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, cmd_ready 0, cmd_valid pulses ignored.
REQ-038 Reset asserted during cycle 2 of SHR count=5 -> next cycle IDLE, select=00, rsp_valid=0, cmd_ready=1.
